spi_dev_cmd: RTL and testbench
==============================

Name: spi_dev_cmd

Overview:
- Command-framing stage directly downstream of spi_dev_core; consumes its user byte interface and CS-edge strobes.
- First MOSI byte of each CS-low transaction is a command ID. Following bytes are payload, presented as write strobes with a running byte count.
- On the MISO side, the first byte returned is a status byte captured at CS fall. Later bytes come from a show-ahead read source, advanced by rd_ack.
- Sits between spi_dev_core and user register/FIFO logic, in place of ad-hoc loopback glue.

Parameters:
- LEN_WIDTH, 8, width of the payload byte counter and cmd_len (saturating).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- usr_mosi_data  in  8  received byte from spi_dev_core
- usr_mosi_stb  in  1  one-cycle pulse, usr_mosi_data valid
- usr_miso_data  out  8  next byte for spi_dev_core to shift out
- usr_miso_ack  in  1  one-cycle pulse, core has latched usr_miso_data
- csn_state  in  1  synchronized CS level (1 = deselected)
- csn_fall  in  1  one-cycle pulse, transaction start
- csn_rise  in  1  one-cycle pulse, transaction end
- status_in  in  8  status byte, sampled at csn_fall
- cmd_id  out  8  latched command byte
- cmd_stb  out  1  one-cycle pulse, cmd_id updated
- cmd_active  out  1  high from command byte accepted until transaction end
- wr_data  out  8  payload byte
- wr_stb  out  1  one-cycle pulse, wr_data valid
- wr_first  out  1  qualifies wr_stb: first payload byte of this command
- cmd_end  out  1  one-cycle pulse, command terminated by CS rise
- cmd_len  out  LEN_WIDTH  payload byte count, valid with cmd_end, held until the next cmd_end
- rd_data  in  8  show-ahead read source byte
- rd_ack  out  1  one-cycle pulse, rd_data consumed; source advances

Behaviour:
- Reset: all outputs 0; state IDLE; counter 0; status_q 0; miso_first 0.
- All registered outputs update one cycle after the causing input strobe.

State machine:
- IDLE: entered on reset. On csn_fall -> CMD; clear counter; status_q <= status_in; miso_first <= 1.
- CMD: on usr_mosi_stb -> cmd_id <= data, cmd_stb pulse, cmd_active <= 1, go to DATA.
- DATA: each usr_mosi_stb -> wr_data <= data, wr_stb pulse, counter + 1 (saturating at 2^LEN_WIDTH-1).
  - wr_first = 1 for the first payload byte only.
- csn_rise in CMD: go to IDLE; no cmd_end (command aborted, no ID received).
- csn_rise in DATA: go to IDLE; cmd_end pulse; cmd_len <= final counter; cmd_active <= 0.
- csn_state high in CMD/DATA without a csn_rise pulse (e.g. core reset): forced to IDLE silently, no cmd_end.
- Simultaneous usr_mosi_stb and csn_rise:
  - In DATA: byte accepted, wr_stb and cmd_end pulse in the same cycle, cmd_len includes the byte.
  - In CMD: cmd_stb pulses, then cmd_end pulses in the same cycle with cmd_len = 0.
- usr_mosi_stb in IDLE: ignored.
- csn_fall while not IDLE (missed rise): restart as a fresh transaction in CMD; no cmd_end for the old one.

MISO:
- usr_miso_data = miso_first ? status_q : rd_data (combinational mux of registered/stable sources).
- usr_miso_ack with miso_first = 1: clear miso_first; no rd_ack.
- usr_miso_ack with miso_first = 0: rd_ack pulse next cycle.
  - Source must present the new rd_data within 1 cycle of rd_ack; the core samples no earlier than one full SPI byte later.
- csn_rise: miso_first unchanged; it is re-armed only at csn_fall.

Arithmetic and reset:
- Counter is unsigned and saturating; it never wraps.
- Async reset mid-transaction returns to IDLE immediately. Bytes until the next csn_fall are ignored.

Test Plan:
- Reset asserted mid-DATA -> all outputs 0 immediately; subsequent usr_mosi_stb bytes ignored until csn_fall.
- csn_fall with status_in=0xA5, MOSI 0x12,0x34,0x56, csn_rise:
  - cmd_stb with cmd_id=0x12.
  - wr_stb x2 (0x34 with wr_first=1, then 0x56 with wr_first=0).
  - cmd_end with cmd_len=2.
  - First MISO byte = 0xA5.
- MISO: after the status ack, 3 usr_miso_ack pulses with rd_data source 0x01,0x02,0x03 -> usr_miso_data sequence 0xA5,0x01,0x02,0x03; exactly 3 rd_ack pulses.
- csn_fall then csn_rise with no bytes -> no cmd_stb, no cmd_end.
  - Next transaction cmd 0x40, no payload -> cmd_end with cmd_len=0.
- LEN_WIDTH=4, 20 payload bytes -> cmd_len=15 (saturated); 20 wr_stb pulses.
- Last payload byte usr_mosi_stb coincident with csn_rise -> wr_stb and cmd_end in the same cycle; cmd_len counts the byte.

Source files
------------

// File: rtl/spi_dev_cmd_if.sv
// Byte-level link between spi_dev_core, the command framer and the user logic behind it.
// The slave modport is the framer's view; the master modport is the surrounding logic's view.
interface spi_dev_cmd_if #(
    parameter int unsigned LEN_WIDTH = 8
);
    // Core-side byte stream and chip-select events
    logic [7:0]           usr_mosi_data;
    logic                 usr_mosi_stb;
    logic [7:0]           usr_miso_data;
    logic                 usr_miso_ack;
    logic                 csn_state;
    logic                 csn_fall;
    logic                 csn_rise;
    logic [7:0]           status_in;

    // User-side command/payload stream
    logic [7:0]           cmd_id;
    logic                 cmd_stb;
    logic                 cmd_active;
    logic [7:0]           wr_data;
    logic                 wr_stb;
    logic                 wr_first;
    logic                 cmd_end;
    logic [LEN_WIDTH-1:0] cmd_len;

    // Show-ahead read source
    logic [7:0]           rd_data;
    logic                 rd_ack;

    modport slave (
        input  usr_mosi_data, usr_mosi_stb, usr_miso_ack,
        input  csn_state, csn_fall, csn_rise, status_in, rd_data,
        output usr_miso_data, cmd_id, cmd_stb, cmd_active,
        output wr_data, wr_stb, wr_first, cmd_end, cmd_len, rd_ack
    );

    modport master (
        output usr_mosi_data, usr_mosi_stb, usr_miso_ack,
        output csn_state, csn_fall, csn_rise, status_in, rd_data,
        input  usr_miso_data, cmd_id, cmd_stb, cmd_active,
        input  wr_data, wr_stb, wr_first, cmd_end, cmd_len, rd_ack
    );
endinterface

// File: rtl/spi_dev_cmd.sv
// Command framer behind spi_dev_core: the first MOSI byte of a CS-low transaction is the
// command ID, later bytes become payload write strobes with a saturating byte count.
// MISO returns a status byte captured at CS fall, then bytes from a show-ahead source.
module spi_dev_cmd #(
    parameter int unsigned LEN_WIDTH = 8
) (
    input logic          clk,
    input logic          rst,
    spi_dev_cmd_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle,
        StCmd,
        StData
    } state_e;

    localparam logic [LEN_WIDTH-1:0] CntMax = '1;

    state_e               state_q, state_d;
    logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
    logic [LEN_WIDTH-1:0] cnt_inc;
    logic [7:0]           status_q, status_d;
    logic                 miso_first_q, miso_first_d;

    logic [7:0]           cmd_id_q, cmd_id_d;
    logic                 cmd_stb_q, cmd_stb_d;
    logic                 cmd_active_q, cmd_active_d;
    logic [7:0]           wr_data_q, wr_data_d;
    logic                 wr_stb_q, wr_stb_d;
    logic                 wr_first_q, wr_first_d;
    logic                 cmd_end_q, cmd_end_d;
    logic [LEN_WIDTH-1:0] cmd_len_q, cmd_len_d;
    logic                 rd_ack_q, rd_ack_d;

    logic                 take_payload;

    // Saturating increment; the count sticks at all-ones instead of wrapping
    assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;

    // A byte arriving with CS rise still belongs to the command; a bare high CS level does not
    assign take_payload = bus.usr_mosi_stb && (bus.csn_rise || !bus.csn_state);

    // Next-state and output decode for framing and the MISO source select
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        status_d     = status_q;
        miso_first_d = miso_first_q;
        cmd_id_d     = cmd_id_q;
        cmd_stb_d    = 1'b0;
        cmd_active_d = cmd_active_q;
        wr_data_d    = wr_data_q;
        wr_stb_d     = 1'b0;
        wr_first_d   = 1'b0;
        cmd_end_d    = 1'b0;
        cmd_len_d    = cmd_len_q;
        rd_ack_d     = 1'b0;

        if (bus.csn_fall) begin
            // Fresh transaction from any state; a missed rise is dropped without cmd_end
            state_d      = StCmd;
            cnt_d        = '0;
            status_d     = bus.status_in;
            miso_first_d = 1'b1;
            cmd_active_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // Stray bytes outside a transaction are ignored
                end

                StCmd: begin
                    if (bus.csn_rise) begin
                        state_d = StIdle;
                        if (bus.usr_mosi_stb) begin
                            // Command byte and end of transaction together: empty command
                            cmd_id_d  = bus.usr_mosi_data;
                            cmd_stb_d = 1'b1;
                            cmd_end_d = 1'b1;
                            cmd_len_d = '0;
                        end
                    end else if (bus.csn_state) begin
                        state_d = StIdle;
                    end else if (bus.usr_mosi_stb) begin
                        cmd_id_d     = bus.usr_mosi_data;
                        cmd_stb_d    = 1'b1;
                        cmd_active_d = 1'b1;
                        state_d      = StData;
                    end
                end

                StData: begin
                    if (take_payload) begin
                        wr_data_d  = bus.usr_mosi_data;
                        wr_stb_d   = 1'b1;
                        wr_first_d = (cnt_q == '0);
                        cnt_d      = cnt_inc;
                    end
                    if (bus.csn_rise) begin
                        state_d      = StIdle;
                        cmd_end_d    = 1'b1;
                        cmd_len_d    = cnt_d;
                        cmd_active_d = 1'b0;
                    end else if (bus.csn_state) begin
                        state_d      = StIdle;
                        cmd_active_d = 1'b0;
                    end
                end

                default: begin
                    state_d = StIdle;
                end
            endcase
        end

        // The status byte is consumed by the first ack; later acks advance the read source
        if (!bus.csn_fall && bus.usr_miso_ack) begin
            if (miso_first_q) begin
                miso_first_d = 1'b0;
            end else begin
                rd_ack_d = 1'b1;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            status_q     <= 8'h00;
            miso_first_q <= 1'b0;
            cmd_id_q     <= 8'h00;
            cmd_stb_q    <= 1'b0;
            cmd_active_q <= 1'b0;
            wr_data_q    <= 8'h00;
            wr_stb_q     <= 1'b0;
            wr_first_q   <= 1'b0;
            cmd_end_q    <= 1'b0;
            cmd_len_q    <= '0;
            rd_ack_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            status_q     <= status_d;
            miso_first_q <= miso_first_d;
            cmd_id_q     <= cmd_id_d;
            cmd_stb_q    <= cmd_stb_d;
            cmd_active_q <= cmd_active_d;
            wr_data_q    <= wr_data_d;
            wr_stb_q     <= wr_stb_d;
            wr_first_q   <= wr_first_d;
            cmd_end_q    <= cmd_end_d;
            cmd_len_q    <= cmd_len_d;
            rd_ack_q     <= rd_ack_d;
        end
    end

    assign bus.usr_miso_data = miso_first_q ? status_q : bus.rd_data;
    assign bus.cmd_id        = cmd_id_q;
    assign bus.cmd_stb       = cmd_stb_q;
    assign bus.cmd_active    = cmd_active_q;
    assign bus.wr_data       = wr_data_q;
    assign bus.wr_stb        = wr_stb_q;
    assign bus.wr_first      = wr_first_q;
    assign bus.cmd_end       = cmd_end_q;
    assign bus.cmd_len       = cmd_len_q;
    assign bus.rd_ack        = rd_ack_q;

endmodule

// File: tb/tb_spi_dev_cmd.sv
// Bench for spi_dev_cmd: two instances (8-bit and 4-bit length counters) share one stimulus;
// a negedge monitor records events, and each test compares them to a transaction-level model.
module tb_spi_dev_cmd;

    typedef logic [7:0] q8_t[$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] mosi_data = 8'h00;
    logic       mosi_stb  = 1'b0;
    logic       miso_ack  = 1'b0;
    logic       csn_state = 1'b1;
    logic       csn_fall  = 1'b0;
    logic       csn_rise  = 1'b0;
    logic [7:0] status_in = 8'h00;
    logic [7:0] rd_data;
    logic       clr       = 1'b0;

    int pass_cnt  = 0;
    int total_cnt = 0;

    spi_dev_cmd_if #(.LEN_WIDTH(8)) ifa ();
    spi_dev_cmd_if #(.LEN_WIDTH(4)) ifb ();

    spi_dev_cmd #(.LEN_WIDTH(8)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    spi_dev_cmd #(.LEN_WIDTH(4)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    assign ifa.usr_mosi_data = mosi_data;
    assign ifa.usr_mosi_stb  = mosi_stb;
    assign ifa.usr_miso_ack  = miso_ack;
    assign ifa.csn_state     = csn_state;
    assign ifa.csn_fall      = csn_fall;
    assign ifa.csn_rise      = csn_rise;
    assign ifa.status_in     = status_in;
    assign ifa.rd_data       = rd_data;
    assign ifb.usr_mosi_data = mosi_data;
    assign ifb.usr_mosi_stb  = mosi_stb;
    assign ifb.usr_miso_ack  = miso_ack;
    assign ifb.csn_state     = csn_state;
    assign ifb.csn_fall      = csn_fall;
    assign ifb.csn_rise      = csn_rise;
    assign ifb.status_in     = status_in;
    assign ifb.rd_data       = rd_data;

    // Observed events
    q8_t oa_cmd, oa_wr, oa_wf, oa_len, ob_len, ob_wf;
    int  ob_wr_cnt = 0;
    int  rd_ack_cnt = 0;
    int  coinc_cnt = 0;
    int  src_idx = 0;

    // Read source: byte k of the stream is k+1, advancing on each rd_ack
    assign rd_data = 8'(src_idx + 1);

    // Expected events from the model
    q8_t e_cmd, e_wr, e_wf, e_lena, e_lenb;
    int  e_coinc = 0;

    // Monitor samples mid-cycle, away from the active edge
    always @(negedge clk) begin
        if (clr) begin
            oa_cmd.delete(); oa_wr.delete(); oa_wf.delete(); oa_len.delete();
            ob_len.delete(); ob_wf.delete();
            ob_wr_cnt  <= 0;
            rd_ack_cnt <= 0;
            coinc_cnt  <= 0;
            src_idx    <= 0;
        end else begin
            if (ifa.cmd_stb) oa_cmd.push_back(ifa.cmd_id);
            if (ifa.wr_stb) begin
                oa_wr.push_back(ifa.wr_data);
                oa_wf.push_back({7'h00, ifa.wr_first});
            end
            if (ifa.cmd_end) oa_len.push_back(ifa.cmd_len);
            if (ifb.cmd_end) ob_len.push_back({4'h0, ifb.cmd_len});
            if (ifb.wr_stb) begin
                ob_wr_cnt <= ob_wr_cnt + 1;
                ob_wf.push_back({7'h00, ifb.wr_first});
            end
            if (ifa.rd_ack) begin
                rd_ack_cnt <= rd_ack_cnt + 1;
                src_idx    <= src_idx + 1;
            end
            if (ifa.cmd_end && (ifa.wr_stb || ifa.cmd_stb)) coinc_cnt <= coinc_cnt + 1;
        end
    end

    function automatic logic [7:0] qat(input q8_t q, input int i);
        return (i < q.size()) ? q[i] : 8'hxx;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        clr = 1'b1;
        @(negedge clk);
        #1;
        clr = 1'b0;
        cycle();
    endtask

    task automatic start(input logic [7:0] st);
        status_in = st;
        csn_fall  = 1'b1;
        csn_state = 1'b0;
        cycle();
        csn_fall  = 1'b0;
    endtask

    task automatic byte_tx(input logic [7:0] b, input bit rise, input int gap);
        mosi_data = b;
        mosi_stb  = 1'b1;
        csn_rise  = rise;
        if (rise) csn_state = 1'b1;
        cycle();
        mosi_stb  = 1'b0;
        csn_rise  = 1'b0;
        repeat (gap) cycle();
    endtask

    task automatic finish_tx();
        csn_rise  = 1'b1;
        csn_state = 1'b1;
        cycle();
        csn_rise  = 1'b0;
        cycle();
    endtask

    // One transaction of n bytes (command + payload); expectations follow the framing rules
    task automatic run_txn(input int n, input bit coinc, input logic [7:0] st);
        logic [7:0] b;
        int         p;
        start(st);
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom_range(0, 255));
            if (i == 0) begin
                e_cmd.push_back(b);
            end else begin
                e_wr.push_back(b);
                e_wf.push_back((i == 1) ? 8'h01 : 8'h00);
            end
            byte_tx(b, coinc && (i == n - 1), $urandom_range(0, 1));
        end
        if (!(coinc && n > 0)) finish_tx();
        if (n > 0) begin
            p = n - 1;
            e_lena.push_back(8'((p > 255) ? 255 : p));
            e_lenb.push_back(8'((p > 15) ? 15 : p));
            if (coinc) e_coinc++;
        end
        repeat (2) cycle();
    endtask

    task automatic test_reset();
        total_cnt++;
        if ({ifa.cmd_id, ifa.cmd_stb, ifa.cmd_active, ifa.wr_data, ifa.wr_stb, ifa.wr_first,
             ifa.cmd_end, ifa.cmd_len, ifa.rd_ack} !== '0)
            $display("FAIL reset_outs_a: outputs not zero after reset");
        else pass_cnt++;
        total_cnt++;
        if ({ifb.cmd_id, ifb.cmd_stb, ifb.cmd_active, ifb.wr_data, ifb.wr_stb, ifb.wr_first,
             ifb.cmd_end, ifb.cmd_len, ifb.rd_ack} !== '0)
            $display("FAIL reset_outs_b: outputs not zero after reset");
        else pass_cnt++;
        total_cnt++;
        if (ifa.usr_miso_data !== 8'h01)
            $display("FAIL reset_miso: got %h expected 01", ifa.usr_miso_data);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        clear_obs();
        start(8'hA5);
        total_cnt++;
        if (ifa.usr_miso_data !== 8'hA5)
            $display("FAIL basic_status: got %h expected a5", ifa.usr_miso_data);
        else pass_cnt++;
        byte_tx(8'h12, 1'b0, 1);
        byte_tx(8'h34, 1'b0, 0);
        byte_tx(8'h56, 1'b0, 2);
        total_cnt++;
        if (ifa.cmd_active !== 1'b1)
            $display("FAIL basic_active: got %b expected 1", ifa.cmd_active);
        else pass_cnt++;
        finish_tx();
        repeat (2) cycle();
        total_cnt++;
        if (oa_cmd.size() != 1 || qat(oa_cmd, 0) !== 8'h12)
            $display("FAIL basic_cmd: got %h (n=%0d) expected 12", qat(oa_cmd, 0), oa_cmd.size());
        else pass_cnt++;
        total_cnt++;
        if (oa_wr.size() != 2 || qat(oa_wr, 0) !== 8'h34 || qat(oa_wr, 1) !== 8'h56)
            $display("FAIL basic_wr: got %h %h (n=%0d) expected 34 56",
                     qat(oa_wr, 0), qat(oa_wr, 1), oa_wr.size());
        else pass_cnt++;
        total_cnt++;
        if (qat(oa_wf, 0) !== 8'h01 || qat(oa_wf, 1) !== 8'h00)
            $display("FAIL basic_first: got %h %h expected 01 00", qat(oa_wf, 0), qat(oa_wf, 1));
        else pass_cnt++;
        total_cnt++;
        if (oa_len.size() != 1 || qat(oa_len, 0) !== 8'd2)
            $display("FAIL basic_len: got %h (n=%0d) expected 02", qat(oa_len, 0), oa_len.size());
        else pass_cnt++;
        total_cnt++;
        if (ifa.cmd_active !== 1'b0)
            $display("FAIL basic_inactive: got %b expected 0", ifa.cmd_active);
        else pass_cnt++;
    endtask

    task automatic test_miso();
        logic [7:0] st;
        logic [7:0] exp;
        clear_obs();
        st = 8'($urandom_range(0, 255));
        start(st);
        for (int k = 0; k < 4; k++) begin
            exp = (k == 0) ? st : 8'(k);
            total_cnt++;
            if (ifa.usr_miso_data !== exp)
                $display("FAIL miso_byte%0d: got %h expected %h", k, ifa.usr_miso_data, exp);
            else pass_cnt++;
            miso_ack = 1'b1;
            cycle();
            miso_ack = 1'b0;
            repeat (2) cycle();
        end
        total_cnt++;
        if (rd_ack_cnt != 3)
            $display("FAIL miso_rd_acks: got %0d expected 3", rd_ack_cnt);
        else pass_cnt++;
        finish_tx();
    endtask

    task automatic test_abort();
        clear_obs();
        start(8'h3C);
        finish_tx();
        repeat (2) cycle();
        total_cnt++;
        if (oa_cmd.size() != 0 || oa_len.size() != 0)
            $display("FAIL abort_empty: got %0d cmd %0d end expected 0 0",
                     oa_cmd.size(), oa_len.size());
        else pass_cnt++;
        start(8'h00);
        byte_tx(8'h40, 1'b0, 1);
        finish_tx();
        repeat (2) cycle();
        total_cnt++;
        if (qat(oa_cmd, 0) !== 8'h40 || oa_len.size() != 1 || qat(oa_len, 0) !== 8'd0)
            $display("FAIL abort_nopayload: cmd %h len %h (n=%0d) expected 40 00",
                     qat(oa_cmd, 0), qat(oa_len, 0), oa_len.size());
        else pass_cnt++;
    endtask

    task automatic test_saturate();
        clear_obs();
        start(8'h00);
        byte_tx(8'hE0, 1'b0, 0);
        for (int i = 0; i < 20; i++) byte_tx(8'(i + 1), 1'b0, i % 2);
        finish_tx();
        repeat (2) cycle();
        total_cnt++;
        if (ob_wr_cnt != 20) $display("FAIL sat_wr_count: got %0d expected 20", ob_wr_cnt);
        else pass_cnt++;
        total_cnt++;
        if (ob_len.size() != 1 || qat(ob_len, 0) !== 8'd15)
            $display("FAIL sat_len4: got %h expected 0f", qat(ob_len, 0));
        else pass_cnt++;
        total_cnt++;
        if (qat(oa_len, 0) !== 8'd20)
            $display("FAIL sat_len8: got %h expected 14", qat(oa_len, 0));
        else pass_cnt++;
        total_cnt++;
        if (qat(ob_wf, 0) !== 8'h01 || qat(ob_wf, 19) !== 8'h00)
            $display("FAIL sat_first: got %h %h expected 01 00", qat(ob_wf, 0), qat(ob_wf, 19));
        else pass_cnt++;
    endtask

    task automatic test_coincident();
        clear_obs();
        start(8'h00);
        byte_tx(8'hC1, 1'b0, 0);
        byte_tx(8'h0A, 1'b0, 0);
        byte_tx(8'h0B, 1'b0, 1);
        byte_tx(8'h0C, 1'b1, 2);
        total_cnt++;
        if (coinc_cnt != 1 || qat(oa_len, 0) !== 8'd3 || qat(oa_wr, 2) !== 8'h0C)
            $display("FAIL coinc_data: same-cycle %0d len %h last %h expected 1 03 0c",
                     coinc_cnt, qat(oa_len, 0), qat(oa_wr, 2));
        else pass_cnt++;
        clear_obs();
        start(8'h00);
        byte_tx(8'h99, 1'b1, 2);
        total_cnt++;
        if (coinc_cnt != 1 || qat(oa_cmd, 0) !== 8'h99 || oa_len.size() != 1 ||
            qat(oa_len, 0) !== 8'd0)
            $display("FAIL coinc_cmd: same-cycle %0d cmd %h len %h expected 1 99 00",
                     coinc_cnt, qat(oa_cmd, 0), qat(oa_len, 0));
        else pass_cnt++;
    endtask

    task automatic test_forced_idle();
        clear_obs();
        start(8'h00);
        byte_tx(8'h61, 1'b0, 0);
        byte_tx(8'h62, 1'b0, 0);
        csn_state = 1'b1;
        repeat (3) cycle();
        total_cnt++;
        if (ifa.cmd_active !== 1'b0 || oa_len.size() != 0)
            $display("FAIL forced_idle: active %b ends %0d expected 0 0",
                     ifa.cmd_active, oa_len.size());
        else pass_cnt++;
    endtask

    task automatic test_missed_rise();
        clear_obs();
        start(8'h00);
        byte_tx(8'h21, 1'b0, 0);
        byte_tx(8'h31, 1'b0, 0);
        start(8'h00);
        byte_tx(8'h77, 1'b0, 0);
        byte_tx(8'h88, 1'b0, 0);
        finish_tx();
        repeat (2) cycle();
        total_cnt++;
        if (oa_cmd.size() != 2 || qat(oa_cmd, 1) !== 8'h77 || oa_len.size() != 1 ||
            qat(oa_len, 0) !== 8'd1)
            $display("FAIL missed_rise: cmds %0d cmd1 %h ends %0d len %h expected 2 77 1 01",
                     oa_cmd.size(), qat(oa_cmd, 1), oa_len.size(), qat(oa_len, 0));
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        start(8'h00);
        byte_tx(8'h5A, 1'b0, 0);
        byte_tx(8'h11, 1'b0, 0);
        byte_tx(8'h22, 1'b0, 0);
        total_cnt++;
        if (ifa.cmd_active !== 1'b1 || ifa.cmd_id !== 8'h5A)
            $display("FAIL rstmid_pre: active %b cmd %h expected 1 5a", ifa.cmd_active, ifa.cmd_id);
        else pass_cnt++;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({ifa.cmd_id, ifa.cmd_stb, ifa.cmd_active, ifa.wr_data, ifa.wr_stb, ifa.wr_first,
             ifa.cmd_end, ifa.cmd_len, ifa.rd_ack} !== '0)
            $display("FAIL rstmid_zero_a: outputs not zero during reset");
        else pass_cnt++;
        total_cnt++;
        if (ifb.cmd_len !== 4'h0 || ifb.cmd_active !== 1'b0)
            $display("FAIL rstmid_zero_b: len %h active %b expected 0 0",
                     ifb.cmd_len, ifb.cmd_active);
        else pass_cnt++;
        repeat (2) cycle();
        rst = 1'b0;
        clear_obs();
        byte_tx(8'h71, 1'b0, 0);
        byte_tx(8'h72, 1'b0, 1);
        byte_tx(8'h73, 1'b0, 0);
        finish_tx();
        repeat (2) cycle();
        total_cnt++;
        if (oa_cmd.size() != 0 || oa_wr.size() != 0 || oa_len.size() != 0)
            $display("FAIL rstmid_ignored: cmd %0d wr %0d end %0d expected 0 0 0",
                     oa_cmd.size(), oa_wr.size(), oa_len.size());
        else pass_cnt++;
    endtask

    task automatic test_random();
        clear_obs();
        e_cmd.delete(); e_wr.delete(); e_wf.delete(); e_lena.delete(); e_lenb.delete();
        e_coinc = 0;
        for (int t = 0; t < 25; t++)
            run_txn($urandom_range(0, 20), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        total_cnt++;
        if (oa_cmd.size() != e_cmd.size() || oa_wr.size() != e_wr.size() ||
            oa_len.size() != e_lena.size() || ob_len.size() != e_lenb.size())
            $display("FAIL rand_counts: cmd %0d/%0d wr %0d/%0d end %0d/%0d",
                     oa_cmd.size(), e_cmd.size(), oa_wr.size(), e_wr.size(),
                     oa_len.size(), e_lena.size());
        else pass_cnt++;
        for (int i = 0; i < e_cmd.size(); i++) begin
            total_cnt++;
            if (qat(oa_cmd, i) !== e_cmd[i])
                $display("FAIL rand_cmd%0d: got %h expected %h", i, qat(oa_cmd, i), e_cmd[i]);
            else pass_cnt++;
        end
        for (int i = 0; i < e_wr.size(); i++) begin
            total_cnt++;
            if (qat(oa_wr, i) !== e_wr[i] || qat(oa_wf, i) !== e_wf[i])
                $display("FAIL rand_wr%0d: got %h/%h expected %h/%h",
                         i, qat(oa_wr, i), qat(oa_wf, i), e_wr[i], e_wf[i]);
            else pass_cnt++;
        end
        for (int i = 0; i < e_lena.size(); i++) begin
            total_cnt++;
            if (qat(oa_len, i) !== e_lena[i] || qat(ob_len, i) !== e_lenb[i])
                $display("FAIL rand_len%0d: got %h/%h expected %h/%h",
                         i, qat(oa_len, i), qat(ob_len, i), e_lena[i], e_lenb[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (coinc_cnt != e_coinc)
            $display("FAIL rand_coinc: got %0d expected %0d", coinc_cnt, e_coinc);
        else pass_cnt++;
    endtask

    initial begin
        repeat (3) cycle();
        rst = 1'b0;
        cycle();
        test_reset();
        test_basic();
        test_miso();
        test_abort();
        test_saturate();
        test_coincident();
        test_forced_idle();
        test_missed_rise();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
